// File: rtl/data_bus_responder.sv
// Data-memory bus responder: word RAM plus timer/LED/7-seg/systick registers at 0x4000_0xxx.
// Define DMEM_RW_BYPASS_EN to return Write_data on a same-cycle read+write of a writable location.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned RAM_AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] clk_count,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic [7:0]  led,
  output logic [11:0] digits,
  output logic        irq
);

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_rd_data;
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [7:0]  r_led;
  logic [11:0] r_digits;

  logic              w_is_ram;
  logic              w_is_per;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [9:0]        w_per_off;
  logic              w_wr_ram;
  logic              w_wr_th;
  logic              w_wr_tl;
  logic              w_wr_tcon;
  logic              w_wr_led;
  logic              w_wr_digits;
  logic              w_tl_max;
  logic [31:0]       w_rd_val;
  logic              w_unused;

  assign w_is_ram  = (Address[31:28] == 4'h0) && ({2'b00, Address[31:2]} < RAM_WORDS);
  assign w_is_per  = (Address[31:12] == 20'h40000);
  assign w_ram_idx = Address[RAM_AW+1:2];
  assign w_per_off = Address[11:2];
  assign w_unused  = ^Address[1:0];

  assign w_wr_ram    = MemWrite && w_is_ram;
  assign w_wr_th     = MemWrite && w_is_per && (w_per_off == 10'd0);
  assign w_wr_tl     = MemWrite && w_is_per && (w_per_off == 10'd1);
  assign w_wr_tcon   = MemWrite && w_is_per && (w_per_off == 10'd2);
  assign w_wr_led    = MemWrite && w_is_per && (w_per_off == 10'd3);
  assign w_wr_digits = MemWrite && w_is_per && (w_per_off == 10'd4);

  assign w_tl_max = (r_tl == 32'hFFFF_FFFF);

`ifdef DMEM_RW_BYPASS_EN
  logic [31:0] w_wr_masked;
  logic        w_writable;

  always_comb begin
    w_wr_masked = Write_data;
    w_writable  = w_is_ram;
    if (w_is_per) begin
      case (w_per_off)
        10'd0, 10'd1: w_writable = 1'b1;
        10'd2: begin
          w_writable  = 1'b1;
          w_wr_masked = {29'b0, Write_data[2:0]};
        end
        10'd3: begin
          w_writable  = 1'b1;
          w_wr_masked = {24'b0, Write_data[7:0]};
        end
        10'd4: begin
          w_writable  = 1'b1;
          w_wr_masked = {20'b0, Write_data[11:0]};
        end
        default: w_writable = 1'b0;
      endcase
    end
  end
`endif

  always_comb begin
    w_rd_val = 32'h0;
    if (w_is_ram) begin
      w_rd_val = r_ram[w_ram_idx];
    end else if (w_is_per) begin
      case (w_per_off)
        10'd0:   w_rd_val = r_th;
        10'd1:   w_rd_val = r_tl;
        10'd2:   w_rd_val = {29'b0, r_tcon};
        10'd3:   w_rd_val = {24'b0, r_led};
        10'd4:   w_rd_val = {20'b0, r_digits};
        10'd5:   w_rd_val = clk_count;
        default: w_rd_val = 32'h0;
      endcase
    end
`ifdef DMEM_RW_BYPASS_EN
    if (MemWrite && w_writable) begin
      w_rd_val = w_wr_masked;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RAM_WORDS; i++) begin
        r_ram[RAM_AW'(i)] <= 32'h0;
      end
    end else if (w_wr_ram) begin
      r_ram[w_ram_idx] <= Write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data <= 32'h0;
      r_th      <= 32'h0;
      r_tl      <= 32'h0;
      r_tcon    <= 3'b000;
      r_led     <= 8'h0;
      r_digits  <= 12'h0;
    end else begin
      if (MemRead) begin
        r_rd_data <= w_rd_val;
      end
      if (w_wr_th) begin
        r_th <= Write_data;
      end
      // CPU writes take priority over the timer's own increment/reload.
      if (w_wr_tl) begin
        r_tl <= Write_data;
      end else if (r_tcon[0]) begin
        r_tl <= w_tl_max ? r_th : r_tl + 32'd1;
      end
      if (w_wr_tcon) begin
        r_tcon <= Write_data[2:0];
      end else if (r_tcon[0] && r_tcon[1] && w_tl_max) begin
        r_tcon[2] <= 1'b1;
      end
      if (w_wr_led) begin
        r_led <= Write_data[7:0];
      end
      if (w_wr_digits) begin
        r_digits <= Write_data[11:0];
      end
    end
  end

  assign Read_data = r_rd_data;
  assign led       = r_led;
  assign digits    = r_digits;
  assign irq       = r_tcon[2];

endmodule
